// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider and its EX-stage requester.
//   div_state_e        : divider FSM state encoding
//   DivStart/DivStop   : start_i levels (request or hold / release)
//   DivResultReady/... : ready_o levels
//   ZeroWord           : all-zero 32-bit word
package iter_divider_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider, responder side of the EX-stage divide handshake.
// One quotient bit per cycle; signed operands are divided as magnitudes and the signs are
// re-applied once the last step is done.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   signed_div_i  : 1 = signed divide, 0 = unsigned; latched at start
//   opdata1_i     : dividend; latched at start
//   opdata2_i     : divisor; latched at start
//   start_i       : DivStart requests/holds an operation, DivStop releases the result
//   annul_i       : abort the in-flight operation
//   result_o      : {remainder, quotient}, registered
//   ready_o       : DivResultReady while result_o is valid, registered
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int unsigned    CntW     = $clog2(DATA_W) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(DATA_W - 1);

    div_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    // {partial remainder, dividend bits still to consume / quotient bits produced, 1}
    logic [2*DATA_W:0]   work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    // Operand magnitudes, taken from the live inputs at the start edge.
    logic [DATA_W-1:0] dividend_abs, divisor_abs;
    assign dividend_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign divisor_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Restoring step. The compare stands in for the sign of the (DATA_W+1)-bit difference;
    // when it passes the true difference is below the divisor, so DATA_W bits hold it.
    logic [DATA_W:0]   upper;
    logic              sub_ok;
    logic [DATA_W-1:0] diff;
    logic [2*DATA_W:0] step_work;
    assign upper     = work_q[2*DATA_W:DATA_W];
    assign sub_ok    = (upper >= {1'b0, divisor_q});
    assign diff      = upper[DATA_W-1:0] - divisor_q;
    assign step_work = sub_ok ? {diff, work_q[DATA_W-1:0], 1'b1}
                              : {upper[DATA_W-1:0], work_q[DATA_W-1:0], 1'b0};

    // Sign fix-up applied when the result is presented.
    logic [DATA_W-1:0] quo_raw, rem_raw, quo_fix, rem_fix;
    assign quo_raw = work_q[DATA_W-1:0];
    assign rem_raw = work_q[2*DATA_W:DATA_W+1];
    assign quo_fix = neg_quo_q ? -quo_raw : quo_raw;
    assign rem_fix = neg_rem_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                        divisor_d = divisor_abs;
                        work_d    = {{DATA_W{1'b0}}, dividend_abs, 1'b0};
                    end
                end
            end

            // Clearing the working state makes DivEnd present an all-zero result.
            DivByZero: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    state_d   = DivEnd;
                    work_d    = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        state_d = DivEnd;
                    end
                end
            end

            DivEnd: begin
                if (start_i == DivStart && !annul_i) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                end else begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end

            default: begin
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: a transaction-level reference model (plain 64-bit
// arithmetic plus edge counting) is compared with the DUT outputs on every negative edge.
module tb_iter_divider;

    localparam int unsigned DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                signed_div = 1'b0;
    logic [DATA_W-1:0]   opdata1 = '0;
    logic [DATA_W-1:0]   opdata2 = '0;
    logic                start = 1'b0;
    logic                annul = 1'b0;
    logic [2*DATA_W-1:0] result;
    logic                ready;

    iter_divider #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    // Reference quotient/remainder: truncating division, remainder takes dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: 0 idle, 1 busy (counting edges since accepted start), 2 result presented.
    int          m_phase = 0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [63:0] m_calc = '0;
    logic [63:0] m_res = '0;
    logic        m_ready = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_ready <= 1'b0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: begin
                    if (start && !annul) begin
                        m_phase <= 1;
                        m_k     <= 0;
                        m_lat   <= (opdata2 == '0) ? 2 : DATA_W + 1;
                        m_calc  <= ref_div(opdata1, opdata2, signed_div);
                    end
                end
                1: begin
                    m_k <= m_k + 1;
                    if (annul) begin
                        m_phase <= 0;
                    end else if (m_k + 1 == m_lat) begin
                        if (!start) begin
                            m_phase <= 0;
                        end else begin
                            m_phase <= 2;
                            m_ready <= 1'b1;
                            m_res   <= m_calc;
                        end
                    end
                end
                default: begin
                    if (annul || !start) begin
                        m_phase <= 0;
                        m_ready <= 1'b0;
                        m_res   <= '0;
                    end
                end
            endcase
        end
    end

    // Hand-computed pins posted by the stimulus, consumed when ready_o is seen.
    int          pin_id = 0;
    int          pin_seen = 0;
    logic [63:0] pin_result = '0;
    int          pin_lat = 0;
    int          stim_timeouts = 0;
    int          to_seen = 0;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    always @(negedge clk) begin
        cycle++;
        checks++;
        if (ready !== m_ready || result !== m_res) begin
            errors++;
            $display("FAIL outputs cycle %0d: ready_o=%0b result_o=%h, required ready=%0b result=%h",
                     cycle, ready, result, m_ready, m_res);
        end
        if (ready === 1'b1 && pin_id != pin_seen) begin
            checks++;
            if (result !== pin_result || m_k != pin_lat) begin
                errors++;
                $display("FAIL pin %0d: result_o=%h after %0d edges, required %h after %0d edges",
                         pin_id, result, m_k, pin_result, pin_lat);
            end
            pin_seen = pin_id;
        end
        if (stim_timeouts != to_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: ready_o not seen within bound (count %0d, required 0)",
                     stim_timeouts);
            to_seen = stim_timeouts;
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input logic pin, input logic [63:0] expv);
        int n;
        @(posedge clk);
        #1;
        if (pin) begin
            pin_result = expv;
            pin_lat    = (b == 32'd0) ? 2 : DATA_W + 1;
            pin_id++;
        end
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        n = 0;
        // Inputs are scrambled while running: only the values latched at start may matter.
        do begin
            @(posedge clk);
            #1;
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom);
            n++;
        end while (ready !== 1'b1 && n < 60);
        if (ready !== 1'b1) stim_timeouts++;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input int steps, input logic use_rst);
        @(posedge clk);
        #1;
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        repeat (steps) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else annul = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        annul = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(32'd100, 32'd7, 1'b0, 5, 1'b1, {32'd2, 32'd14});
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
        do_op(32'd1234, 32'd0, 1'b0, 2, 1'b1, 64'h0);
        do_op(32'h8000_0000, 32'd0, 1'b1, 0, 1'b1, 64'h0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, {32'h0, 32'h8000_0000});
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1, {32'h0, 32'hFFFF_FFFF});
        do_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 1'b1, {32'h7FFF_FFFE, 32'd1});

        abort_op(32'd5000, 32'd3, 1'b0, 10, 1'b0);
        do_op(32'd9, 32'd3, 1'b0, 0, 1'b1, {32'd0, 32'd3});
        abort_op(32'hDEAD_BEEF, 32'd17, 1'b1, 20, 1'b1);
        do_op(32'hFFFF_FF9C, 32'd9, 1'b1, 0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF5});

        // start with annul in FREE must not launch anything
        @(posedge clk);
        #1;
        opdata1 = 32'd50;
        opdata2 = 32'd5;
        start   = 1'b1;
        annul   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if (i % 9 == 4) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (i % 8 == 7) begin
                abort_op(ra, rb, 1'($urandom), $urandom_range(1, 30), 1'($urandom));
            end else begin
                do_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'b0, 64'h0);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
